// File: rtl/icu_io.sv
// icu_io: addressable I/O responder supplying the ICU data operand and capturing its result into output latches
module icu_io #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] OUT_RESET   = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] addr,
   input  logic       write,
   input  logic       result,
   output logic       data,
   input  logic [7:0] pin_in,
   output logic [7:0] pin_out,
   output logic       wr_err,
   output logic [7:0] wr_cnt
);
   logic [SYNC_STAGES-1:0][7:0] sync;
   logic [7:0] in_s;
   assign in_s = sync[SYNC_STAGES-1];
   // synchronizer chain: pin_in enters stage 0, last stage feeds the read mux
   always_ff @(posedge clk)
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], pin_in};
   // unregistered read mux so the operand is available in the cycle addr is presented
   always_comb data = addr[3] ? pin_out[addr[2:0]] : in_s[addr[2:0]];
   // latch writes, accepted-write counter and sticky illegal-write flag; reset drops a colliding write
   always_ff @(posedge clk)
      if (rst) begin
         pin_out <= OUT_RESET;
         wr_cnt  <= '0;
         wr_err  <= 1'b0;
      end else if (write) begin
         if (addr[3]) begin
            pin_out[addr[2:0]] <= result;
            wr_cnt             <= wr_cnt + 8'd1;
         end else begin
            wr_err <= 1'b1;
         end
      end
endmodule

// File: tb/tb_icu_io.sv
// tb_icu_io: directed self-checking bench for icu_io at 2 and 3 synchronizer stages
module tb_icu_io;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] addr = '0;
   logic       write = 1'b0;
   logic       result = 1'b0;
   logic [7:0] pin_in = '0;
   logic       data2, data3, err2, err3;
   logic [7:0] out2, out3, cnt2, cnt3;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   icu_io #(.SYNC_STAGES(2), .OUT_RESET(8'hA5)) u2 (
      .clk(clk), .rst(rst), .addr(addr), .write(write), .result(result),
      .data(data2), .pin_in(pin_in), .pin_out(out2), .wr_err(err2), .wr_cnt(cnt2));
   icu_io #(.SYNC_STAGES(3), .OUT_RESET(8'hA5)) u3 (
      .clk(clk), .rst(rst), .addr(addr), .write(write), .result(result),
      .data(data3), .pin_in(pin_in), .pin_out(out3), .wr_err(err3), .wr_cnt(cnt3));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; write = 1'b0; pin_in = 8'h00;
      step();
      rst = 1'b0;
      vectors++; if (out2 !== 8'hA5) begin miscompares++; $display("FAIL reset_pin_out got %h want a5", out2); end
      vectors++; if (cnt2 !== 8'h00) begin miscompares++; $display("FAIL reset_wr_cnt got %h want 00", cnt2); end
      vectors++; if (err2 !== 1'b0) begin miscompares++; $display("FAIL reset_wr_err got %b want 0", err2); end
      vectors++; if (out3 !== 8'hA5) begin miscompares++; $display("FAIL reset_pin_out3 got %h want a5", out3); end
      addr = 4'hA; #1;
      vectors++; if (data2 !== 1'b1) begin miscompares++; $display("FAIL reset_read_a got %b want 1", data2); end
      addr = 4'h3; #1;
      vectors++; if (data2 !== 1'b0) begin miscompares++; $display("FAIL reset_read_in3 got %b want 0", data2); end
   endtask

   task automatic test_input_sync();
      pin_in = 8'h08; addr = 4'h3;
      step();
      vectors++; if (data2 !== 1'b0) begin miscompares++; $display("FAIL sync2_edge1 got %b want 0", data2); end
      vectors++; if (data3 !== 1'b0) begin miscompares++; $display("FAIL sync3_edge1 got %b want 0", data3); end
      step();
      vectors++; if (data2 !== 1'b1) begin miscompares++; $display("FAIL sync2_edge2 got %b want 1", data2); end
      vectors++; if (data3 !== 1'b0) begin miscompares++; $display("FAIL sync3_edge2 got %b want 0", data3); end
      step();
      vectors++; if (data3 !== 1'b1) begin miscompares++; $display("FAIL sync3_edge3 got %b want 1", data3); end
      addr = 4'h2; #1;
      vectors++; if (data2 !== 1'b0) begin miscompares++; $display("FAIL sync_other_bit got %b want 0", data2); end
   endtask

   task automatic test_write_readback();
      addr = 4'hC; result = 1'b1; write = 1'b1; #1;
      vectors++; if (data2 !== 1'b0) begin miscompares++; $display("FAIL same_cycle_read got %b want 0", data2); end
      step();
      write = 1'b0;
      vectors++; if (out2 !== 8'hB5) begin miscompares++; $display("FAIL write_c_pin_out got %h want b5", out2); end
      vectors++; if (cnt2 !== 8'h01) begin miscompares++; $display("FAIL write_c_cnt got %h want 01", cnt2); end
      vectors++; if (data2 !== 1'b1) begin miscompares++; $display("FAIL readback_c got %b want 1", data2); end
      result = 1'b0; write = 1'b1;
      step();
      write = 1'b0;
      vectors++; if (out2 !== 8'hA5) begin miscompares++; $display("FAIL clear_c_pin_out got %h want a5", out2); end
      vectors++; if (cnt2 !== 8'h02) begin miscompares++; $display("FAIL clear_c_cnt got %h want 02", cnt2); end
   endtask

   task automatic test_illegal_write();
      addr = 4'h2; result = 1'b1; write = 1'b1;
      step();
      write = 1'b0;
      vectors++; if (out2 !== 8'hA5) begin miscompares++; $display("FAIL illegal_pin_out got %h want a5", out2); end
      vectors++; if (cnt2 !== 8'h02) begin miscompares++; $display("FAIL illegal_cnt got %h want 02", cnt2); end
      vectors++; if (err2 !== 1'b1) begin miscompares++; $display("FAIL illegal_err got %b want 1", err2); end
      for (int i = 0; i < 10; i++) begin
         addr = 4'(i); result = i[0];
         step();
      end
      vectors++; if (err2 !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b want 1", err2); end
      vectors++; if (out2 !== 8'hA5) begin miscompares++; $display("FAIL idle_pin_out got %h want a5", out2); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++; if (err2 !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b want 0", err2); end
      vectors++; if (cnt2 !== 8'h00) begin miscompares++; $display("FAIL err_clear_cnt got %h want 00", cnt2); end
   endtask

   task automatic test_wrap();
      addr = 4'hF; write = 1'b1;
      for (int i = 0; i < 255; i++) begin
         result = ~i[0];
         step();
      end
      vectors++; if (cnt2 !== 8'hFF) begin miscompares++; $display("FAIL cnt_ff got %h want ff", cnt2); end
      result = 1'b0;
      step();
      write = 1'b0;
      vectors++; if (cnt2 !== 8'h00) begin miscompares++; $display("FAIL cnt_wrap got %h want 00", cnt2); end
      vectors++; if (out2 !== 8'h25) begin miscompares++; $display("FAIL wrap_pin_out got %h want 25", out2); end
      result = 1'b1;
      step();
      step();
      vectors++; if (out2 !== 8'h25) begin miscompares++; $display("FAIL nowrite_pin_out got %h want 25", out2); end
      vectors++; if (cnt2 !== 8'h00) begin miscompares++; $display("FAIL nowrite_cnt got %h want 00", cnt2); end
      vectors++; if (err2 !== 1'b0) begin miscompares++; $display("FAIL nowrite_err got %b want 0", err2); end
   endtask

   task automatic test_back_to_back();
      write = 1'b1;
      addr = 4'h8; result = 1'b1; step();
      addr = 4'h9; result = 1'b1; step();
      addr = 4'h8; result = 1'b0; step();
      write = 1'b0;
      vectors++; if (out2 !== 8'h26) begin miscompares++; $display("FAIL b2b_pin_out got %h want 26", out2); end
      vectors++; if (cnt2 !== 8'h03) begin miscompares++; $display("FAIL b2b_cnt got %h want 03", cnt2); end
      addr = 4'h9; #1;
      vectors++; if (data2 !== 1'b1) begin miscompares++; $display("FAIL b2b_read9 got %b want 1", data2); end
      addr = 4'h8; #1;
      vectors++; if (data2 !== 1'b0) begin miscompares++; $display("FAIL b2b_read8 got %b want 0", data2); end
   endtask

   task automatic test_reset_collision();
      rst = 1'b1; write = 1'b1; addr = 4'h9; result = 1'b1;
      out_before: begin end
      step();
      rst = 1'b0; write = 1'b0;
      vectors++; if (out2 !== 8'hA5) begin miscompares++; $display("FAIL coll_pin_out got %h want a5", out2); end
      vectors++; if (cnt2 !== 8'h00) begin miscompares++; $display("FAIL coll_cnt got %h want 00", cnt2); end
      vectors++; if (out3 !== 8'hA5) begin miscompares++; $display("FAIL coll_pin_out3 got %h want a5", out3); end
      vectors++; if (cnt3 !== 8'h00) begin miscompares++; $display("FAIL coll_cnt3 got %h want 00", cnt3); end
   endtask

   initial begin
      test_reset();
      test_input_sync();
      test_write_readback();
      test_illegal_write();
      test_wrap();
      test_back_to_back();
      test_reset_collision();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/icu_io.md
# icu_io

Addressable I/O responder on the far side of the ICU's `write`/`result`/`data` interface. It supplies the ICU's 1-bit `data` operand from one of 16 addresses: 8 synchronized external inputs and readback of 8 output latches. It captures the ICU's `result` into an addressed output latch when `write` is asserted. It sits between the ICU and the chip pins, with the address field sourced from the instruction word.

## Interface
- `SYNC_STAGES`, default 2: flop stages on each external input (legal 2–3).
- `OUT_RESET`, default 8'h00: value loaded into the output latches on reset.
- `clk`  in  1  rising-edge clock shared with the ICU.
- `rst`  in  1  reset, synchronous and active-high.
- `addr`  in  4  I/O address from the instruction word. Values 0–7 select inputs, 8–15 select output latches.
- `write`  in  1  ICU store strobe, sampled on rising `clk`.
- `result`  in  1  ICU result bit to store.
- `data`  out  1  selected operand bit to the ICU, combinational from `addr`.
- `pin_in`  in  8  asynchronous external inputs.
- `pin_out`  out  8  registered output latches.
- `wr_err`  out  1  sticky flag: a write was attempted to an input address.
- `wr_cnt`  out  8  count of accepted latch writes, wraps.

## Operation
- Input path: each `pin_in[i]` passes through a `SYNC_STAGES`-deep flop chain. `in_s[i]` is the last stage.
- Read mux:
  - `addr[3]=0`: `data = in_s[addr[2:0]]`.
  - `addr[3]=1`: `data = pin_out[addr[2:0]]`.
  - No register in the mux path, so the ICU sees the operand in the same cycle it presents `addr`.
- Write, on rising `clk` with `write=1`:
  - `addr[3]=1`: `pin_out[addr[2:0]] <= result`. All other latches hold. `wr_cnt <= wr_cnt+1`, mod 256, wrapping 8'hFF→8'h00.
  - `addr[3]=0`: no latch changes, `wr_cnt` holds, `wr_err <= 1`.
- `wr_err` is cleared only by `rst`.
- `write=0`: all latches, `wr_cnt` and `wr_err` hold, whatever the value of `addr`/`result`.
- Reset, synchronous, on rising `clk` with `rst=1`:
  - `pin_out <= OUT_RESET`.
  - All sync flops `<= 0`.
  - `wr_cnt <= 0`.
  - `wr_err <= 0`.
  - Reset has priority over a simultaneous `write`, and the write is dropped.
- Reset mid-operation: takes effect on the first rising edge with `rst=1`. There is no partial state.

## Timing
- Reset values: `pin_out=OUT_RESET`, `wr_cnt=0`, `wr_err=0`. `data` follows the mux: reads 0 on input addresses until synchronized data arrives.
- Input latency: a `pin_in` change is visible on `data` `SYNC_STAGES` rising edges later. This is 2 cycles at the default.
- Write latency: `pin_out`, `wr_cnt` and `wr_err` update on the edge that samples `write=1`.
- Read-after-write: readback of the written latch reflects the new value in the cycle after that edge.
- Same-cycle readback: reading an address in the same cycle it is written returns the old value. There is no bypass.
- Back-to-back writes to the same or different latches are accepted every cycle. The last write to a bit wins.
- The block has no handshake and never stalls the ICU.

## Test plan
- Reset: drive `rst=1` for 1 edge with `OUT_RESET=8'hA5` -> `pin_out=8'hA5`, `wr_cnt=0`, `wr_err=0`. Then drive `addr=4'hA` -> `data=1`.
- Input sync: set `pin_in=8'h08` and `addr=4'h3` -> `data=0` after edge 1, `data=1` after edge 2. Check again with `SYNC_STAGES=3`: `data=1` after edge 3.
- Write/readback:
  - Edge 1: `write=1`, `addr=4'hC`, `result=1` -> `pin_out[4]=1`, `wr_cnt=1`.
  - Same cycle as the write: `data` at `addr=4'hC` = old value.
  - Next cycle: `data` at `addr=4'hC` = 1.
  - Next edge: write `result=0` to 4'hC -> `pin_out[4]=0`.
- Illegal write: `write=1`, `addr=4'h2`, `result=1` -> `pin_out` unchanged, `wr_cnt` unchanged, `wr_err=1`. `wr_err` stays 1 through 10 idle cycles and clears only on `rst`.
- Wrap and stress:
  - 256 consecutive writes to 4'hF with alternating `result` -> `wr_cnt` returns to 0, `pin_out[7]` equals the last `result`, all other latches unchanged.
  - Write with `write=0` and `result=1` -> nothing changes.
- Reset collision: `rst=1` and `write=1` to 4'h9 with `result=1` on the same edge -> `pin_out=OUT_RESET` and `wr_cnt=0`.
